// File: rtl/line_mem_arbiter.sv
// rtl/line_mem_arbiter.sv - icache/dcache line-miss arbiter onto a single 4-beat burst memory port
module line_mem_arbiter #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BEAT_W-1:0] mem_wdata,
    input  logic [BEAT_W-1:0] mem_rdata,
    input  logic              mem_resp
);
    localparam int BEATS = LINE_W / BEAT_W;
    localparam int CNT_W = $clog2(BEATS);

    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              grant;       // 1 = data cache owns the current burst
    logic              last_grant;  // 1 = data cache was granted last
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] line_q;
    logic [LINE_W-1:0] rd_line;
    logic              i_pend;
    logic              d_pend;
    logic              pick_d;
    logic              last_beat;

    assign i_pend    = i_read;
    assign d_pend    = d_read | d_write;
    assign pick_d    = d_pend && (!i_pend || !last_grant);
    assign last_beat = (cnt == CNT_W'(BEATS - 1));

    // Line buffer with the incoming beat merged in, so the final beat can be
    // handed to the requester on the same edge it is accepted.
    always_comb begin
        rd_line = line_q;
        rd_line[int'(cnt) * BEAT_W +: BEAT_W] = mem_rdata;
    end

    assign mem_read  = (state == RD_BURST);
    assign mem_write = (state == WR_BURST);
    assign mem_addr  = addr_q & ~ADDR_W'(LINE_W / 8 - 1);
    assign mem_wdata = line_q[int'(cnt) * BEAT_W +: BEAT_W];
    assign i_resp    = (state == DONE) && !grant;
    assign d_resp    = (state == DONE) && grant;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            grant      <= 1'b0;
            last_grant <= 1'b0;
            addr_q     <= '0;
            line_q     <= '0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_pend || d_pend) begin
                        grant      <= pick_d;
                        last_grant <= pick_d;
                        addr_q     <= pick_d ? d_addr : i_addr;
                        cnt        <= '0;
                        if (pick_d && d_write) begin
                            line_q <= d_wdata;
                            state  <= WR_BURST;
                        end else begin
                            state  <= RD_BURST;
                        end
                    end
                end
                RD_BURST: begin
                    if (mem_resp) begin
                        line_q <= rd_line;
                        cnt    <= cnt + CNT_W'(1);
                        if (last_beat) begin
                            state <= DONE;
                            if (grant) d_rdata <= rd_line;
                            else       i_rdata <= rd_line;
                        end
                    end
                end
                WR_BURST: begin
                    if (mem_resp) begin
                        cnt <= cnt + CNT_W'(1);
                        if (last_beat) state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_line_mem_arbiter.sv
// tb/tb_line_mem_arbiter.sv - scoreboard bench for line_mem_arbiter
module tb_line_mem_arbiter;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         i_read = 1'b0;
    logic [31:0]  i_addr = '0;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic         d_read = 1'b0;
    logic         d_write = 1'b0;
    logic [31:0]  d_addr = '0;
    logic [255:0] d_wdata = '0;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_addr;
    logic [63:0]  mem_wdata;
    logic [63:0]  mem_rdata = '0;
    logic         mem_resp = 1'b0;

    line_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         is_d;
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] line;
    } txn_t;

    txn_t         exp_q[$];
    txn_t         mon_t;
    int           tests = 0;
    int           errors = 0;
    int           bidx;
    int           cyc;
    logic         gap = 1'b0;
    logic         gap_phase = 1'b0;
    logic         idle_resp = 1'b0;
    logic [255:0] resp_line;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic is_d, input logic wr, input logic [31:0] a, input logic [255:0] l);
        txn_t t;
        t.is_d = is_d; t.wr = wr; t.addr = a; t.line = l;
        exp_q.push_back(t);
    endtask

    task automatic wait_resp(output int c);
        c = 1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            c++;
            if (i_resp || d_resp) return;
        end
        tests++; errors++;
        $display("FAIL resp_timeout: no response within 40 cycles");
    endtask

    // Bench-side beat index, advanced by every accepted beat.
    always @(posedge clk or negedge rst) begin
        if (!rst) bidx <= 0;
        else if ((mem_read || mem_write) && mem_resp) bidx <= (bidx == 3) ? 0 : bidx + 1;
    end

    // Memory model: serves the scoreboard head and checks the burst it sees.
    always @(negedge clk) begin
        if (mem_read || mem_write) begin
            if (exp_q.size() == 0) begin
                tests++; errors++;
                $display("FAIL unexpected_burst: addr %h with empty scoreboard", mem_addr);
                mem_resp = 1'b0;
            end else begin
                resp_line = exp_q[0].line;
                chk("mem_addr", 256'(mem_addr), 256'(exp_q[0].addr));
                chk("mem_write", 256'(mem_write), 256'(exp_q[0].wr));
                chk("mem_read", 256'(mem_read), 256'(!exp_q[0].wr));
                if (exp_q[0].wr) chk("mem_wdata", 256'(mem_wdata), 256'(resp_line[bidx*64 +: 64]));
                if (gap && !gap_phase) begin
                    mem_resp  = 1'b0;
                    gap_phase = 1'b1;
                end else begin
                    mem_resp  = 1'b1;
                    gap_phase = 1'b0;
                    mem_rdata = resp_line[bidx*64 +: 64];
                end
            end
        end else begin
            mem_resp  = idle_resp;
            mem_rdata = '0;
            gap_phase = 1'b0;
        end
    end

    // Response monitor: pops the scoreboard on every completion pulse.
    always @(negedge clk) begin
        if (i_resp || d_resp) begin
            if (i_resp && d_resp) begin
                tests++; errors++;
                $display("FAIL dual_resp: i_resp and d_resp both high");
            end
            if (exp_q.size() == 0) begin
                tests++; errors++;
                $display("FAIL unexpected_resp: i_resp=%0b d_resp=%0b", i_resp, d_resp);
            end else begin
                mon_t = exp_q.pop_front();
                chk("resp_port", 256'(d_resp), 256'(mon_t.is_d));
                if (!mon_t.wr) chk(mon_t.is_d ? "d_rdata" : "i_rdata",
                                   mon_t.is_d ? d_rdata : i_rdata, mon_t.line);
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_read"}, 256'(mem_read), '0);
        chk({tag, "_mem_write"}, 256'(mem_write), '0);
        chk({tag, "_i_resp"}, 256'(i_resp), '0);
        chk({tag, "_d_resp"}, 256'(d_resp), '0);
        chk({tag, "_mem_addr"}, 256'(mem_addr), '0);
        chk({tag, "_mem_wdata"}, 256'(mem_wdata), '0);
        chk({tag, "_i_rdata"}, i_rdata, '0);
        chk({tag, "_d_rdata"}, d_rdata, '0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        // Single inst read, back-to-back beats; unaligned address
        i_addr = 32'h0000_0064;
        i_read = 1'b1;
        push(1'b0, 1'b0, 32'h0000_0060, {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}});
        wait_resp(cyc);
        i_read = 1'b0;
        chk("i_resp_cycle", 256'(cyc), 256'(6));
        @(negedge clk);

        // Tie with both held: data first, then inst on the re-sampled tie
        i_addr = 32'h0000_1000;
        d_addr = 32'h0000_2040;
        push(1'b1, 1'b0, 32'h0000_2040, {64'h0D0D_0000_0000_0003, 64'h0D0D_0000_0000_0002,
                                          64'h0D0D_0000_0000_0001, 64'h0D0D_0000_0000_0000});
        push(1'b0, 1'b0, 32'h0000_1000, {64'h1A1A_0000_0000_0003, 64'h1A1A_0000_0000_0002,
                                          64'h1A1A_0000_0000_0001, 64'h1A1A_0000_0000_0000});
        i_read = 1'b1;
        d_read = 1'b1;
        wait_resp(cyc);
        chk("tie_first_is_d", 256'(d_resp), 256'(1));
        wait_resp(cyc);
        chk("tie_second_is_i", 256'(i_resp), 256'(1));
        i_read = 1'b0;
        d_read = 1'b0;
        @(negedge clk);

        // Writeback with one idle cycle between beats
        gap     = 1'b1;
        d_addr  = 32'h8000_0020;
        d_wdata = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                   64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        d_write = 1'b1;
        push(1'b1, 1'b1, 32'h8000_0020, d_wdata);
        wait_resp(cyc);
        d_write = 1'b0;
        chk("wr_d_resp", 256'(d_resp), 256'(1));
        gap = 1'b0;
        @(negedge clk);

        // d_read and d_write together: write wins
        d_addr  = 32'h0000_0140;
        d_wdata = {64'h5555_0000_0000_0004, 64'h5555_0000_0000_0003,
                   64'h5555_0000_0000_0002, 64'h5555_0000_0000_0001};
        d_read  = 1'b1;
        d_write = 1'b1;
        push(1'b1, 1'b1, 32'h0000_0140, d_wdata);
        wait_resp(cyc);
        d_read  = 1'b0;
        d_write = 1'b0;
        chk("rdwr_d_resp", 256'(d_resp), 256'(1));
        @(negedge clk);

        // mem_resp pulsed while idle: nothing starts, next read begins at beat 0
        idle_resp = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("idle_mem_read", 256'(mem_read), '0);
            chk("idle_mem_write", 256'(mem_write), '0);
        end
        i_addr = 32'h0000_03FC;
        i_read = 1'b1;
        push(1'b0, 1'b0, 32'h0000_03E0, {64'h6666_0000_0000_0003, 64'h6666_0000_0000_0002,
                                          64'h6666_0000_0000_0001, 64'h6666_0000_0000_0000});
        wait_resp(cyc);
        i_read = 1'b0;
        chk("idle_pulse_read_cycle", 256'(cyc), 256'(6));
        idle_resp = 1'b0;
        @(negedge clk);

        // Reset during a read burst at beat 2
        i_addr = 32'h0000_0500;
        i_read = 1'b1;
        push(1'b0, 1'b0, 32'h0000_0500, {64'h7777_0000_0000_0003, 64'h7777_0000_0000_0002,
                                          64'h7777_0000_0000_0001, 64'h7777_0000_0000_0000});
        cyc = 0;
        while (!(mem_read && bidx == 2) && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("reached_beat2", 256'(bidx), 256'(2));
        rst = 1'b0;
        #1;
        chk_all_zero("midburst_reset");
        exp_q.delete();
        i_read = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        i_addr = 32'h0000_0600;
        i_read = 1'b1;
        push(1'b0, 1'b0, 32'h0000_0600, {64'h8888_0000_0000_0003, 64'h8888_0000_0000_0002,
                                          64'h8888_0000_0000_0001, 64'h8888_0000_0000_0000});
        wait_resp(cyc);
        i_read = 1'b0;
        chk("post_reset_read_cycle", 256'(cyc), 256'(6));

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 256'(exp_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule

// File: doc/line_mem_arbiter.md
# line_mem_arbiter

Arbitrates cache-line misses from the instruction cache and the data cache onto the single burst-memory port that the `mp4` top exposes to the testbench. Each granted request becomes one 4-beat, 64-bit burst read or write. Read beats are assembled into a 256-bit line and returned to the requester with a one-cycle response pulse. The block sits directly below both caches inside `mp4` and drives `itf.mem_*` upstream of physical memory.

## Interface
- `LINE_W`, default 256: cache line width in bits.
- `BEAT_W`, default 64: burst beat width in bits. `BEATS = LINE_W/BEAT_W` (4).
- `ADDR_W`, default 32: address width.

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `i_read`  in  1  icache line read request (level, held until `i_resp`).
- `i_addr`  in  ADDR_W  icache line address.
- `i_rdata`  out  LINE_W  returned icache line.
- `i_resp`  out  1  icache completion pulse.
- `d_read`  in  1  dcache line read request (level).
- `d_write`  in  1  dcache writeback request (level).
- `d_addr`  in  ADDR_W  dcache line address.
- `d_wdata`  in  LINE_W  dcache writeback line.
- `d_rdata`  out  LINE_W  returned dcache line.
- `d_resp`  out  1  dcache completion pulse.
- `mem_read`  out  1  burst read active.
- `mem_write`  out  1  burst write active.
- `mem_addr`  out  ADDR_W  line-aligned burst address.
- `mem_wdata`  out  BEAT_W  current write beat.
- `mem_rdata`  in  BEAT_W  current read beat.
- `mem_resp`  in  1  one beat accepted or delivered this cycle.

## Operation
- State machine: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE arbitration:
  - With one requester pending, grant it.
  - With both ports pending, grant the port not granted last. `last_grant` resets to inst, so data wins the first tie.
  - A data request goes to WR_BURST if `d_write` is high; `d_write` wins if `d_read` and `d_write` are both high. Otherwise RD_BURST.
  - An inst request always goes to RD_BURST.
- On grant, latch grant, address and (for writes) `d_wdata`. Clear the beat counter (`$clog2(BEATS)` bits) and update `last_grant`.
- `mem_addr` = {latched addr[ADDR_W-1:5], 5'b0}. Held constant for the whole burst.
- RD_BURST, on each `mem_resp`: write `mem_rdata` into line slice [BEAT_W*k +: BEAT_W], k = counter, then increment. The beat with k = BEATS-1 moves to DONE.
- WR_BURST: `mem_wdata` = latched line slice k. Advance on `mem_resp` the same way; the last beat moves to DONE.
- DONE lasts exactly one cycle:
  - Pulse the granted port's `*_resp`. Its `*_rdata` holds the assembled line; for writes, `*_rdata` is don't-care.
  - Next state is IDLE.
- `i_rdata`/`d_rdata` keep their last value until overwritten by a later read.
- `mem_resp` is ignored in IDLE and DONE.
- Requests arriving during a burst wait; the arbiter never preempts a burst.

## Timing
- Reset values: state IDLE, counter 0, `last_grant` inst; `mem_read`, `mem_write`, `i_resp`, `d_resp` all 0; `mem_addr`, `mem_wdata`, `i_rdata`, `d_rdata` all 0.
- Reset mid-burst returns to IDLE immediately (asynchronously) and drops `mem_read`/`mem_write`. The partial burst is abandoned and no resp is issued.
- Request sampled high at edge N: `mem_read`/`mem_write` are high during cycle N+1. They are decoded from registered state and stay high until the edge that accepts the last beat.
- With back-to-back `mem_resp`, minimum latency from request to `*_resp` is 6 cycles: grant, 4 beats, DONE.
- `mem_resp` gaps stall the counter with no timeout; the outputs hold.
- The requester must deassert its request in the cycle after `*_resp`. IDLE re-samples in that cycle, so holding the request starts a new transaction.
- A minimum of one IDLE cycle separates consecutive bursts.

## Test plan
- Reset with `rst`=0 during an active RD_BURST at beat 2 -> all outputs 0 the same cycle. After release, a fresh `i_read` restarts at beat 0.
- `i_read`=1, `i_addr`=0x0000_0064, `mem_resp` every cycle with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> `mem_addr`=0x0000_0060, `i_resp` pulse at cycle 6, `i_rdata`={44..,33..,22..,11..}.
- `d_write`=1, `d_addr`=0x8000_0020, `d_wdata` = beats A,B,C,D (low beat A), `mem_resp` with one idle cycle between beats -> `mem_wdata` sequence A,B,C,D, each held until its resp; one `d_resp` pulse; `mem_read` stays 0.
- `i_read` and `d_read` rise in the same cycle, both held -> data served first, then inst. Repeating the tie -> inst served first.
- `d_read` and `d_write` both high -> a write burst is issued.
- `mem_resp` pulsed while idle -> no state change, counter stays 0.
